// File: rtl/tone_gen.sv
// Sine-wave tone generator.
// Emits 12-bit offset-binary samples (midscale 2048) at a rate of one sample
// every SAMPLE_DIV clocks. Samples are drawn from a 256-point sine table
// indexed by the top byte of a 16-bit phase accumulator, and the table value
// is attenuated by an arithmetic right shift.
// A burst runs for burst_len samples, or runs continuously when burst_len is 0.
// A burst ends either with a one-cycle done strobe or when stop aborts it.
module tone_gen #(
    parameter int SAMPLE_DIV = 5000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] freq_word,
    input  logic [2:0]  amp,
    input  logic [15:0] burst_len,
    output logic [11:0] sample,
    output logic        sample_valid,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);
    localparam logic [11:0] MIDSCALE = 12'd2048;

    state_t        state_r;
    state_t        state_nx;
    logic [15:0]   phase_r;
    logic [15:0]   div_r;
    logic [15:0]   count_r;
    logic [15:0]   fw_r;
    logic [2:0]    amp_r;
    logic [15:0]   len_r;
    logic [11:0]   sample_r;
    logic          sample_valid_r;
    logic          busy_r;
    logic          done_r;

    logic          accept_s;
    logic          abort_s;
    logic          idle_stop_s;
    logic          emit_s;
    logic [15:0]   count_inc_s;
    logic signed [11:0] sine_s;
    logic signed [11:0] shifted_s;
    logic [11:0]   sample_nx_s;

    // Quarter-wave magnitude table: round(2047*sin(pi*k/128)) for k = 0..64.
    function automatic logic [10:0] quarter_lut(input logic [6:0] k);
        logic [10:0] v;
        case (k)
            7'd0:  v = 11'd0;    7'd1:  v = 11'd50;   7'd2:  v = 11'd100;  7'd3:  v = 11'd151;
            7'd4:  v = 11'd201;  7'd5:  v = 11'd251;  7'd6:  v = 11'd300;  7'd7:  v = 11'd350;
            7'd8:  v = 11'd399;  7'd9:  v = 11'd449;  7'd10: v = 11'd497;  7'd11: v = 11'd546;
            7'd12: v = 11'd594;  7'd13: v = 11'd642;  7'd14: v = 11'd690;  7'd15: v = 11'd737;
            7'd16: v = 11'd783;  7'd17: v = 11'd830;  7'd18: v = 11'd875;  7'd19: v = 11'd920;
            7'd20: v = 11'd965;  7'd21: v = 11'd1009; 7'd22: v = 11'd1052; 7'd23: v = 11'd1095;
            7'd24: v = 11'd1137; 7'd25: v = 11'd1179; 7'd26: v = 11'd1219; 7'd27: v = 11'd1259;
            7'd28: v = 11'd1299; 7'd29: v = 11'd1337; 7'd30: v = 11'd1375; 7'd31: v = 11'd1411;
            7'd32: v = 11'd1447; 7'd33: v = 11'd1483; 7'd34: v = 11'd1517; 7'd35: v = 11'd1550;
            7'd36: v = 11'd1582; 7'd37: v = 11'd1614; 7'd38: v = 11'd1644; 7'd39: v = 11'd1674;
            7'd40: v = 11'd1702; 7'd41: v = 11'd1729; 7'd42: v = 11'd1756; 7'd43: v = 11'd1781;
            7'd44: v = 11'd1805; 7'd45: v = 11'd1828; 7'd46: v = 11'd1850; 7'd47: v = 11'd1871;
            7'd48: v = 11'd1891; 7'd49: v = 11'd1910; 7'd50: v = 11'd1927; 7'd51: v = 11'd1944;
            7'd52: v = 11'd1959; 7'd53: v = 11'd1973; 7'd54: v = 11'd1986; 7'd55: v = 11'd1997;
            7'd56: v = 11'd2008; 7'd57: v = 11'd2017; 7'd58: v = 11'd2025; 7'd59: v = 11'd2032;
            7'd60: v = 11'd2037; 7'd61: v = 11'd2041; 7'd62: v = 11'd2045; 7'd63: v = 11'd2046;
            7'd64: v = 11'd2047;
            default: v = 11'd0;
        endcase
        return v;
    endfunction

    // Full 256-point signed sine. Quadrant 1 and quadrant 3 read the quarter
    // table mirrored; the lower half-wave (idx[7] set) is the negated upper one.
    function automatic logic signed [11:0] sine_lut(input logic [7:0] idx);
        logic [6:0]         k;
        logic signed [11:0] mag;
        if (idx[6]) begin
            k = 7'd64 - {1'b0, idx[5:0]};
        end else begin
            k = {1'b0, idx[5:0]};
        end
        mag = $signed({1'b0, quarter_lut(k)});
        if (idx[7]) begin
            return -mag;
        end else begin
            return mag;
        end
    endfunction

    // Next sample: attenuated sine, shifted into offset-binary around midscale.
    always_comb begin
        sine_s      = sine_lut(phase_r[15:8]);
        shifted_s   = sine_s >>> amp_r;
        sample_nx_s = MIDSCALE + $unsigned(shifted_s);
        count_inc_s = count_r + 16'd1;
    end

    // Next-state logic and per-edge control strobes.
    always_comb begin
        state_nx    = state_r;
        accept_s    = 1'b0;
        abort_s     = 1'b0;
        idle_stop_s = 1'b0;
        emit_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && !stop) begin
                    state_nx = RUN;
                    accept_s = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
                if (stop) begin
                    idle_stop_s = 1'b1;
                end else begin
                    idle_stop_s = 1'b0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nx = IDLE;
                    abort_s  = 1'b1;
                end else if (div_r == DIV_LAST) begin
                    emit_s = 1'b1;
                    if ((len_r != 16'd0) && (count_inc_s == len_r)) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = RUN;
                    end
                end else begin
                    state_nx = RUN;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Burst datapath: latched parameters, phase accumulator, divider, counter, outputs.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            phase_r        <= 16'd0;
            div_r          <= 16'd0;
            count_r        <= 16'd0;
            fw_r           <= 16'd0;
            amp_r          <= 3'd0;
            len_r          <= 16'd0;
            sample_r       <= MIDSCALE;
            sample_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            sample_valid_r <= emit_s;
            done_r         <= (state_r == DONE);
            busy_r         <= (state_r != IDLE);
            if (accept_s) begin
                fw_r    <= freq_word;
                amp_r   <= amp;
                len_r   <= burst_len;
                phase_r <= 16'd0;
                div_r   <= 16'd0;
                count_r <= 16'd0;
            end else if ((state_r == RUN) && !abort_s) begin
                if (div_r == DIV_LAST) begin
                    div_r <= 16'd0;
                end else begin
                    div_r <= div_r + 16'd1;
                end
                if (emit_s) begin
                    phase_r <= phase_r + fw_r;
                    count_r <= count_inc_s;
                end
            end
            // Sample value uses the phase before this edge's increment.
            if (abort_s || idle_stop_s) begin
                sample_r <= MIDSCALE;
            end else if (emit_s) begin
                sample_r <= sample_nx_s;
            end
        end
    end

    assign sample       = sample_r;
    assign sample_valid = sample_valid_r;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule

// File: tb/tb_tone_gen.sv
// Directed self-checking bench for tone_gen with SAMPLE_DIV = 4.
module tb_tone_gen;

    logic        CLK;
    logic        RST;
    logic        start;
    logic        stop;
    logic [15:0] freq_word;
    logic [2:0]  amp;
    logic [15:0] burst_len;
    logic [11:0] sample;
    logic        sample_valid;
    logic        busy;
    logic        done;

    int n_cmp;
    int n_err;

    tone_gen #(.SAMPLE_DIV(4)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .start        (start),
        .stop         (stop),
        .freq_word    (freq_word),
        .amp          (amp),
        .burst_len    (burst_len),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy),
        .done         (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present a single-cycle start; returns just after the start edge.
    task automatic pulse_start(input logic [15:0] fw, input logic [2:0] a, input logic [15:0] len);
        freq_word = fw;
        amp       = a;
        burst_len = len;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0; start = 1'b1; stop = 1'b0;
        freq_word = 16'h0000; amp = 3'd0; burst_len = 16'd1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (sample !== 12'd2048) begin n_err++; $display("FAIL rst_sample got=%0d exp=2048", sample); end
            n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL rst_sv got=%b exp=0", sample_valid); end
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got=%b exp=0", done); end
        end
        // start held across reset release is accepted on the first edge with RST=1
        RST = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_cmp++; if (sample_valid !== (k == 4)) begin n_err++; $display("FAIL first_start_sv k=%0d got=%b exp=%b", k, sample_valid, (k == 4)); end
            n_cmp++; if (busy !== (k <= 5)) begin n_err++; $display("FAIL first_start_busy k=%0d got=%b exp=%b", k, busy, (k <= 5)); end
            n_cmp++; if (done !== (k == 5)) begin n_err++; $display("FAIL first_start_done k=%0d got=%b exp=%b", k, done, (k == 5)); end
        end
    endtask

    task automatic test_quarter_wave();
        logic [11:0] exp_s;
        pulse_start(16'h4000, 3'd0, 16'd4);
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_cmp++; if (sample_valid !== (k % 4 == 0 && k <= 16)) begin n_err++; $display("FAIL qw_sv k=%0d got=%b", k, sample_valid); end
            if (k == 4 || k == 8 || k == 12 || k == 16) begin
                case (k)
                    4:       exp_s = 12'd2048;
                    8:       exp_s = 12'd4095;
                    12:      exp_s = 12'd2048;
                    default: exp_s = 12'd1;
                endcase
                n_cmp++; if (sample !== exp_s) begin n_err++; $display("FAIL qw_sample k=%0d got=%0d exp=%0d", k, sample, exp_s); end
            end
            n_cmp++; if (done !== (k == 17)) begin n_err++; $display("FAIL qw_done k=%0d got=%b exp=%b", k, done, (k == 17)); end
            n_cmp++; if (busy !== (k <= 17)) begin n_err++; $display("FAIL qw_busy k=%0d got=%b exp=%b", k, busy, (k <= 17)); end
        end
        n_cmp++; if (sample !== 12'd1) begin n_err++; $display("FAIL qw_hold_after_done got=%0d exp=1", sample); end
    endtask

    task automatic test_attenuation();
        pulse_start(16'h4000, 3'd1, 16'd2);
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_cmp++; if (sample_valid !== (k == 4 || k == 8)) begin n_err++; $display("FAIL att_sv k=%0d got=%b", k, sample_valid); end
            if (k == 4) begin
                n_cmp++; if (sample !== 12'd2048) begin n_err++; $display("FAIL att_s1 got=%0d exp=2048", sample); end
            end
            if (k == 8) begin
                n_cmp++; if (sample !== 12'd3071) begin n_err++; $display("FAIL att_s2 got=%0d exp=3071", sample); end
            end
            n_cmp++; if (done !== (k == 9)) begin n_err++; $display("FAIL att_done k=%0d got=%b", k, done); end
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL att_busy_end got=%b exp=0", busy); end
        // negative peak with one-step attenuation floors to -1024
        pulse_start(16'h4000, 3'd1, 16'd4);
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 16) begin
                n_cmp++; if (sample_valid !== 1'b1) begin n_err++; $display("FAIL att_neg_sv got=%b exp=1", sample_valid); end
                n_cmp++; if (sample !== 12'd1024) begin n_err++; $display("FAIL att_neg_sample got=%0d exp=1024", sample); end
            end
        end
    endtask

    task automatic test_continuous_abort();
        int n_sv;
        int n_done;
        n_sv = 0;
        n_done = 0;
        pulse_start(16'h0100, 3'd0, 16'd0);
        // parameter changes mid-burst must not take effect
        freq_word = 16'h4000; amp = 3'd3; burst_len = 16'd1;
        for (int k = 1; k <= 49; k++) begin
            tick();
            if (k == 19) start = 1'b1;
            if (k == 20) start = 1'b0;
            if (sample_valid === 1'b1) n_sv++;
            if (done === 1'b1) n_done++;
            n_cmp++; if (sample_valid !== (k % 4 == 0)) begin n_err++; $display("FAIL cont_sv k=%0d got=%b", k, sample_valid); end
            if (k == 4) begin
                n_cmp++; if (sample !== 12'd2048) begin n_err++; $display("FAIL cont_s1 got=%0d exp=2048", sample); end
            end
            if (k == 8) begin
                n_cmp++; if (sample !== 12'd2098) begin n_err++; $display("FAIL cont_s2 got=%0d exp=2098", sample); end
            end
            if (k == 12) begin
                n_cmp++; if (sample !== 12'd2148) begin n_err++; $display("FAIL cont_s3 got=%0d exp=2148", sample); end
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL abort_sv got=%b exp=0", sample_valid); end
        n_cmp++; if (sample !== 12'd2048) begin n_err++; $display("FAIL abort_sample got=%0d exp=2048", sample); end
        for (int k = 51; k <= 62; k++) begin
            tick();
            if (sample_valid === 1'b1) n_sv++;
            if (done === 1'b1) n_done++;
            if (k == 51) begin
                n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", busy); end
            end
        end
        n_cmp++; if (n_sv !== 12) begin n_err++; $display("FAIL cont_strobe_count got=%0d exp=12", n_sv); end
        n_cmp++; if (n_done !== 0) begin n_err++; $display("FAIL cont_done_count got=%0d exp=0", n_done); end
        n_cmp++; if (sample !== 12'd2048) begin n_err++; $display("FAIL abort_hold got=%0d exp=2048", sample); end
    endtask

    task automatic test_back_to_back();
        // start and stop together in IDLE: ignored
        freq_word = 16'h4000; amp = 3'd0; burst_len = 16'd2;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_cmp++; if (busy !== 1'b0 || sample_valid !== 1'b0) begin n_err++; $display("FAIL startstop_idle k=%0d busy=%b sv=%b exp 0/0", k, busy, sample_valid); end
        end
        pulse_start(16'h4000, 3'd0, 16'd1);
        for (int k = 1; k <= 5; k++) tick();
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done1 got=%b exp=1", done); end
        // new start on the edge right after done is visible
        pulse_start(16'h4000, 3'd0, 16'd2);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 1) begin
                n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy got=%b exp=1", busy); end
            end
            if (k == 4) begin
                n_cmp++; if (sample_valid !== 1'b1 || sample !== 12'd2048) begin n_err++; $display("FAIL b2b_s1 sv=%b sample=%0d exp 1/2048", sample_valid, sample); end
            end
            if (k == 8) begin
                n_cmp++; if (sample_valid !== 1'b1 || sample !== 12'd4095) begin n_err++; $display("FAIL b2b_s2 sv=%b sample=%0d exp 1/4095", sample_valid, sample); end
            end
        end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done2 got=%b exp=1", done); end
        tick();
    endtask

    task automatic test_reset_mid();
        int n_bad;
        n_bad = 0;
        pulse_start(16'h2000, 3'd0, 16'd4);
        for (int k = 1; k <= 8; k++) tick();
        n_cmp++; if (sample !== 12'd3495) begin n_err++; $display("FAIL mid_pre_sample got=%0d exp=3495", sample); end
        RST = 1'b0;
        tick();
        RST = 1'b1;
        n_cmp++; if (sample !== 12'd2048) begin n_err++; $display("FAIL mid_rst_sample got=%0d exp=2048", sample); end
        n_cmp++; if (sample_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL mid_rst_flags sv=%b busy=%b done=%b exp 0/0/0", sample_valid, busy, done); end
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done === 1'b1 || sample_valid === 1'b1 || busy === 1'b1) n_bad++;
        end
        n_cmp++; if (n_bad !== 0) begin n_err++; $display("FAIL mid_after_rst_activity got=%0d exp=0", n_bad); end
        pulse_start(16'h4000, 3'd0, 16'd2);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 4) begin
                n_cmp++; if (sample !== 12'd2048) begin n_err++; $display("FAIL mid_restart_s1 got=%0d exp=2048", sample); end
            end
            if (k == 8) begin
                n_cmp++; if (sample !== 12'd4095) begin n_err++; $display("FAIL mid_restart_s2 got=%0d exp=4095", sample); end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_quarter_wave();
        test_attenuation();
        test_continuous_abort();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
